// File: rtl/ac_pkg.sv
// ac_pkg: shared I2S framing helpers and sample-pair type for the codec and mstClk sides
package ac_pkg;
  localparam int AC_DATA_WDT = 24;
  localparam int AC_SLOT_WDT = 32;
  localparam int AC_BCLK_DIV = 4;
  function automatic int frame_bits(input int slot_wdt);
    return 2 * slot_wdt;
  endfunction
  function automatic int half_div(input int bclk_div);
    return bclk_div / 2;
  endfunction
  localparam int FRAME_BITS = frame_bits(AC_SLOT_WDT);
  localparam int HALF_DIV = half_div(AC_BCLK_DIV);
  typedef struct packed {
    logic signed [AC_DATA_WDT-1:0] l;
    logic signed [AC_DATA_WDT-1:0] r;
  } ac_pair_t;
endpackage

// File: rtl/ac_i2s_clkgen.sv
// ac_i2s_clkgen: BCLK/LRCK divider chain with bit-edge and frame strobes
module ac_i2s_clkgen import ac_pkg::*; #(
  parameter int SLOT_WDT = AC_SLOT_WDT,
  parameter int BCLK_DIV = AC_BCLK_DIV,
  localparam int BW = $clog2(2 * SLOT_WDT),
  localparam int DW = $clog2(BCLK_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          i2sBclk,
  output logic          i2sLrck,
  output logic          fallStb,
  output logic          riseStb,
  output logic          frameWrap,
  output logic [BW-1:0] slotBit
);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  // strobes decode the current counter position; next-state feeds the registered pins
  always_comb begin
    fallStb = div_cnt == DW'(BCLK_DIV - 1);
    riseStb = div_cnt == DW'(half_div(BCLK_DIV));
    frameWrap = fallStb && bit_cnt == BW'(frame_bits(SLOT_WDT) - 1);
    slotBit = bit_cnt >= BW'(SLOT_WDT) ? bit_cnt - BW'(SLOT_WDT) : bit_cnt;
    div_nxt = fallStb ? '0 : div_cnt + 1'b1;
    bit_nxt = frameWrap ? '0 : fallStb ? bit_cnt + 1'b1 : bit_cnt;
  end
  // pins are registered from the next counter values so they line up with the counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      i2sBclk <= 1'b0;
      i2sLrck <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      i2sBclk <= div_nxt >= DW'(half_div(BCLK_DIV));
      i2sLrck <= bit_nxt >= BW'(SLOT_WDT);
    end
  end
endmodule

// File: rtl/ac_i2s_serdes.sv
// ac_i2s_serdes: codec-side I2S master serdes with frame tick; AC_LOOPBACK_EN adds DAC-to-ADC loopback
module ac_i2s_serdes import ac_pkg::*; #(
  parameter int DATA_WDT = AC_DATA_WDT,
  parameter int SLOT_WDT = AC_SLOT_WDT,
  parameter int BCLK_DIV = AC_BCLK_DIV,
  localparam int BW = $clog2(2 * SLOT_WDT)
) (
  input  logic                clk,
  input  logic                reset,
`ifdef AC_LOOPBACK_EN
  input  logic                loopback,
`endif
  output logic                acTick,
  output logic [DATA_WDT-1:0] acAdcDataL,
  output logic [DATA_WDT-1:0] acAdcDataR,
  input  logic [DATA_WDT-1:0] acDacDataL,
  input  logic [DATA_WDT-1:0] acDacDataR,
  output logic                i2sBclk,
  output logic                i2sLrck,
  output logic                i2sDacDat,
  input  logic                i2sAdcDat
);
  logic fall_stb, rise_stb, frame_wrap, slot_last, dac_ok, adc_ok, adc_bit;
  logic [BW-1:0] slot_bit, nb;
  logic [DATA_WDT-1:0] out_sh, sh_r, sr_l, sr_r;
  ac_i2s_clkgen #(.SLOT_WDT(SLOT_WDT), .BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk(clk),
    .reset(reset),
    .i2sBclk(i2sBclk),
    .i2sLrck(i2sLrck),
    .fallStb(fall_stb),
    .riseStb(rise_stb),
    .frameWrap(frame_wrap),
    .slotBit(slot_bit)
  );
  // nb is the slot bit about to start after the next falling BCLK
  always_comb begin
    nb = slot_bit + 1'b1;
    slot_last = slot_bit == BW'(SLOT_WDT - 1);
    dac_ok = nb <= BW'(DATA_WDT);
    adc_ok = slot_bit != '0 && slot_bit <= BW'(DATA_WDT);
`ifdef AC_LOOPBACK_EN
    adc_bit = loopback ? i2sDacDat : i2sAdcDat;
`else
    adc_bit = i2sAdcDat;
`endif
  end
  // out_sh shifts the active slot word MSB first; sh_r holds the right word until its slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      i2sDacDat <= 1'b0;
      out_sh <= '0;
      sh_r <= '0;
    end else begin
      if (fall_stb) i2sDacDat <= dac_ok ? out_sh[DATA_WDT-1] : 1'b0;
      if (frame_wrap) begin
        out_sh <= acDacDataL;
        sh_r <= acDacDataR;
      end else if (fall_stb && slot_last) out_sh <= sh_r;
      else if (fall_stb && dac_ok) out_sh <= out_sh << 1;
    end
  end
  // ADC bits shift in on rising BCLK; words and the tick publish at frame wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_l <= '0;
      sr_r <= '0;
      acAdcDataL <= '0;
      acAdcDataR <= '0;
      acTick <= 1'b0;
    end else begin
      if (rise_stb && adc_ok && i2sLrck) sr_r <= {sr_r[DATA_WDT-2:0], adc_bit};
      if (rise_stb && adc_ok && !i2sLrck) sr_l <= {sr_l[DATA_WDT-2:0], adc_bit};
      if (frame_wrap) begin
        acAdcDataL <= sr_l;
        acAdcDataR <= sr_r;
        acTick <= 1'b1;
      end else if (fall_stb && slot_last && !i2sLrck) acTick <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ac_i2s_serdes.sv
// tb_ac_i2s_serdes: frame-table bench with codec model for ac_i2s_serdes
module tb_ac_i2s_serdes;
  localparam int DW = 24;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic acTick, i2sBclk, i2sLrck, i2sDacDat;
  logic i2sAdcDat = 1'b0;
  logic [DW-1:0] acAdcDataL, acAdcDataR;
  logic [DW-1:0] acDacDataL = '0;
  logic [DW-1:0] acDacDataR = '0;
`ifdef AC_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  always #5 clk = ~clk;
  ac_i2s_serdes dut (
    .clk(clk),
    .reset(reset),
`ifdef AC_LOOPBACK_EN
    .loopback(loopback),
`endif
    .acTick(acTick),
    .acAdcDataL(acAdcDataL),
    .acAdcDataR(acAdcDataR),
    .acDacDataL(acDacDataL),
    .acDacDataR(acDacDataR),
    .i2sBclk(i2sBclk),
    .i2sLrck(i2sLrck),
    .i2sDacDat(i2sDacDat),
    .i2sAdcDat(i2sAdcDat)
  );
  typedef struct {
    logic [DW-1:0] dl;
    logic [DW-1:0] dm;
    logic [DW-1:0] dr;
    logic [DW-1:0] al;
    logic [DW-1:0] ar;
  } row_t;
  row_t tbl[8];
  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  int tim_err = 0;
  int pad_err = 0;
  logic [DW-1:0] cap_l = '0;
  logic [DW-1:0] cap_r = '0;
  logic [DW-1:0] cod_l = '0;
  logic [DW-1:0] cod_r = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (state %0d)", nm, act, exp, k);
    end
  endtask
  task automatic mon();
    int p = (k / 4) % 64;
    int b = p % 32;
    bit side = p >= 32;
    if (i2sBclk !== ((k % 4) >= 2) || i2sLrck !== side || acTick !== (k >= 256 && k % 256 < 128)) tim_err++;
    if (k % 4 == 2) begin
      if (b >= 1 && b <= DW) begin
        if (side) cap_r[5'(DW-b)] = i2sDacDat;
        else cap_l[5'(DW-b)] = i2sDacDat;
      end else if (i2sDacDat !== 1'b0) pad_err++;
    end
    i2sAdcDat = (b >= 1 && b <= DW) ? (side ? cod_r[5'(DW-b)] : cod_l[5'(DW-b)]) : 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    mon();
  endtask
  task automatic out_zero(input string tag);
    chk({tag, "_bclk"}, i2sBclk, 0);
    chk({tag, "_lrck"}, i2sLrck, 0);
    chk({tag, "_dacdat"}, i2sDacDat, 0);
    chk({tag, "_tick"}, acTick, 0);
    chk({tag, "_adc_l"}, acAdcDataL, 0);
    chk({tag, "_adc_r"}, acAdcDataR, 0);
  endtask
  task automatic run(input int s, input int n);
    row_t r, q;
    for (int f = 0; f < n; f++) begin
      r = tbl[s+f];
      if (f == 0) q = '{default: '0};
      else q = tbl[s+f-1];
      acDacDataL = r.dl;
      acDacDataR = r.dr;
      cod_l = r.al;
      cod_r = r.ar;
      chk("adc_l_start", acAdcDataL, q.al);
      chk("adc_r_start", acAdcDataR, q.ar);
      repeat (255) begin
        step();
        if (k % 256 == 40) acDacDataL = r.dm;
      end
      chk("dac_l_wire", cap_l, q.dm);
      chk("dac_r_wire", cap_r, q.dr);
      chk("dac_pad_zero", pad_err, 0);
      chk("frame_timing", tim_err, 0);
      chk("adc_l_hold", acAdcDataL, q.al);
      chk("adc_r_hold", acAdcDataR, q.ar);
      tim_err = 0;
      pad_err = 0;
      step();
    end
  endtask
  initial begin
    tbl[0] = '{24'hA50F3C, 24'hA50F3C, 24'h800001, 24'h123456, 24'hFEDCBA};
    tbl[1] = '{24'h000001, 24'h000001, 24'h000000, 24'h7FFFFF, 24'h800000};
    tbl[2] = '{24'h000001, 24'h7FFFFF, 24'h555555, 24'h000000, 24'hFFFFFF};
    tbl[3] = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'h800001, 24'h0AAAAA};
    tbl[4] = '{24'h123456, 24'h123456, 24'h654321, 24'h000001, 24'h000000};
    tbl[5] = '{24'hC3A5F0, 24'hC3A5F0, 24'h0F0F0F, 24'h5A5A5A, 24'hA5A5A5};
    tbl[6] = '{24'h111111, 24'h111111, 24'h222222, 24'h333333, 24'h444444};
    tbl[7] = '{24'h000000, 24'h000000, 24'h000000, 24'hABCDEF, 24'h000001};
    repeat (3) @(negedge clk);
    out_zero("reset");
    reset = 1'b1;
    k = 0;
    run(0, 6);
    while (k % 256 != 160) step();
    chk("pre_reset_timing", tim_err, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_zero("midreset");
    reset = 1'b1;
    k = 0;
    tim_err = 0;
    pad_err = 0;
    run(6, 2);
`ifdef AC_LOOPBACK_EN
    loopback = 1'b1;
    acDacDataL = 24'hC0FFEE;
    acDacDataR = 24'h0BEEF0;
    repeat (512) step();
    chk("loop_adc_l", acAdcDataL, 24'hC0FFEE);
    chk("loop_adc_r", acAdcDataR, 24'h0BEEF0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
